fu_alu_sched: RTL and testbench
===============================

# fu_alu_sched

Issue scheduler for the shared integer ALU (`fu_alu`). It accepts micro-ops from `NREQ` issue ports and grants one per cycle by round-robin. The granted `fu_input_t` is driven into one internal `fu_alu` instance, and the result is registered into a 2-entry output queue. The queue drains to the writeback/CDB port under a valid/ready handshake. The block sits between the ALU issue queues and writeback, and owns all sequencing and back-pressure for the ALU.

## Interface
- `NREQ`, default 2: number of issue ports; must be ≥ 2.
- `OQ_DEPTH`, default 2: output queue entries; fixed at 2 for this revision.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `flush_i`  in  1  pipeline flush; kills queued and in-flight results.
- `req_valid_i`  in  NREQ  port i holds a valid micro-op.
- `req_fuinput_i`  in  NREQ × fu_input_t  micro-op per port.
- `req_ready_o`  out  NREQ  one-hot grant; port i's op is consumed this cycle.
- `wb_valid_o`  out  1  output queue head is valid.
- `wb_fuoutput_o`  out  fu_output_t  head result (`pc`, `id`, `prd`, `rdval`).
- `wb_ready_i`  in  1  writeback accepts the head this cycle.
- `busy_o`  out  1  queue count ≠ 0.

## Operation
- **State:** round-robin pointer `rr` (log2 NREQ bits), 2-entry circular queue (`head`, `tail`, `count` 0..2).
- **Grant enable:** `count < 2 && !flush_i`.
  - Grant is not conditioned on `wb_ready_i`, so there is no combinational path from `wb_ready_i` to `req_ready_o`.
- **Grant:** the first i with `req_valid_i[i]`, searching from `rr` upward and wrapping at NREQ-1→0.
  - `req_ready_o` is one-hot or zero.
  - It is never asserted for a port with valid low.
- **Pointer update:** on a grant to port g, `rr ← (g+1) mod NREQ`. With no grant, `rr` holds.
- **ALU input:** the ALU sees `req_fuinput_i[g]`. When nothing is granted, the ALU input is don't-care and nothing is written.
- **Push:** on a grant, the ALU output is written at `tail`.
- **Pop:** `wb_valid_o && wb_ready_i`.
- **Queue accounting:**
  - Push and pop in the same cycle leave `count` unchanged.
  - Pop is legal when `count == 2`, but that cycle still grants nothing, because the enable is evaluated on the registered count.
  - `head` and `tail` wrap modulo 2.
- **Flush:**
  - `count`, `head` and `tail` clear next edge.
  - No grant that cycle.
  - `wb_valid_o` low from the next cycle.
  - `rr` holds.
  - A pop coinciding with flush is still a completed transfer.
- **Widths:** `rdval` is XLEN, passed unmodified from the ALU. `pc`, `id` and `prd` are copied from the granted input.
- **Stability:** head contents stay stable while `wb_valid_o && !wb_ready_i`.

## Timing
- **Reset values:**
  - `req_ready_o` = 0 (combinational from `count` = 0 after reset, so it may assert as soon as valid is seen).
  - `wb_valid_o` = 0, `busy_o` = 0, `rr` = 0, `count` = 0.
  - `wb_fuoutput_o` is don't-care while valid is low.
- **Latency:** granted in cycle N → `wb_valid_o` with that result in cycle N+1.
- **Throughput:**
  - With `wb_ready_i` held high, 1 op/cycle sustained and `count` oscillates at ≤ 1.
  - With `wb_ready_i` low, at most 2 grants, then `req_ready_o` = 0 until a pop lowers `count` (grants resume the cycle after the pop).
- **Reset mid-operation:** all state clears immediately (asynchronous); queued results are lost.
- **Ordering:** results leave in grant order.

## Test plan
1. **Reset / idle.** Assert `rst` mid-stream with count = 2.
   - Required: `wb_valid_o`, `busy_o` and `req_ready_o` drop at once.
   - Required: after release with no requests, outputs stay 0.
2. **Single op.** Port 0 issues ADD with rs1 = 5, rs2 = 7, `prd` = 12, with `wb_ready_i` = 1.
   - Required: `req_ready_o` = 01 in cycle N.
   - Required: `wb_valid_o` in N+1 with `rdval` = 12 and `prd` = 12.
   - Required: `busy_o` low in N+2.
3. **Round-robin fairness.** Both ports hold valid for 6 cycles, `wb_ready_i` = 1.
   - Required: grants alternate 01, 10, 01, 10, 01, 10.
   - Required: results appear in the same order, one per cycle.
4. **Back-pressure.** `wb_ready_i` = 0 while port 1 streams SUB 10−3, SLT −1<1, XOR.
   - Required: 2 grants, then `req_ready_o` = 0 for ≥ 3 cycles.
   - Required: the head stays `rdval` = 7 and stable.
   - Raise `wb_ready_i`. Required: 7, then 1, drain; the third op is granted the cycle after the first pop, and its XOR result follows.
5. **Flush.** With count = 2 and both ports valid, pulse `flush_i`.
   - Required: no grant that cycle and `wb_valid_o` = 0 next cycle.
   - Required: `rr` unchanged, so the next grant goes to the same port that would have won before the flush.
6. **Word op.** ADDW with rs1 = 0x7FFFFFFF, rs2 = 1.
   - Required: `rdval` = 0xFFFFFFFF80000000 one cycle after grant.

Source files
------------

// File: rtl/fu_alu_sched.sv
// ============================================================================
// fu_alu_sched : round-robin issue scheduler around the shared integer ALU
// Rev 1.0
// ============================================================================
`default_nettype none

package fu_alu_pkg;
    localparam int XLEN = 64;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_ADDW = 4'd10,
        ALU_SUBW = 4'd11
    } alu_op_e;

    typedef struct packed {
        alu_op_e         op;
        logic [XLEN-1:0] pc;
        logic [7:0]      id;
        logic [6:0]      prd;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } fu_input_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [7:0]      id;
        logic [6:0]      prd;
        logic [XLEN-1:0] rdval;
    } fu_output_t;
endpackage

module fu_alu
    import fu_alu_pkg::*;
(
    input  fu_input_t  in_i,
    output fu_output_t out_o
);
    logic [31:0]     w_word;
    logic [XLEN-1:0] w_res;

    always_comb begin
        w_word = '0;
        w_res  = '0;
        case (in_i.op)
            ALU_ADD:  w_res = in_i.rs1 + in_i.rs2;
            ALU_SUB:  w_res = in_i.rs1 - in_i.rs2;
            ALU_SLT:  w_res = {{(XLEN-1){1'b0}}, $signed(in_i.rs1) < $signed(in_i.rs2)};
            ALU_SLTU: w_res = {{(XLEN-1){1'b0}}, in_i.rs1 < in_i.rs2};
            ALU_AND:  w_res = in_i.rs1 & in_i.rs2;
            ALU_OR:   w_res = in_i.rs1 | in_i.rs2;
            ALU_XOR:  w_res = in_i.rs1 ^ in_i.rs2;
            ALU_SLL:  w_res = in_i.rs1 << in_i.rs2[5:0];
            ALU_SRL:  w_res = in_i.rs1 >> in_i.rs2[5:0];
            ALU_SRA:  w_res = $unsigned($signed(in_i.rs1) >>> in_i.rs2[5:0]);
            // Word ops compute on the low 32 bits and sign-extend the result.
            ALU_ADDW: begin
                w_word = in_i.rs1[31:0] + in_i.rs2[31:0];
                w_res  = {{(XLEN-32){w_word[31]}}, w_word};
            end
            ALU_SUBW: begin
                w_word = in_i.rs1[31:0] - in_i.rs2[31:0];
                w_res  = {{(XLEN-32){w_word[31]}}, w_word};
            end
            default:  w_res = '0;
        endcase
        out_o = '{pc: in_i.pc, id: in_i.id, prd: in_i.prd, rdval: w_res};
    end
endmodule

module fu_alu_sched
    import fu_alu_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int OQ_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic [NREQ-1:0]  req_valid_i,
    input  fu_input_t        req_fuinput_i [NREQ],
    output logic [NREQ-1:0]  req_ready_o,
    output logic             wb_valid_o,
    output fu_output_t       wb_fuoutput_o,
    input  logic             wb_ready_i,
    output logic             busy_o
);
    localparam int         RRW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0] C_FULL = 2'(OQ_DEPTH);

    logic [RRW-1:0] rr_q, rr_d;
    logic [1:0]     count_q, count_d;
    logic           head_q, head_d;
    logic           tail_q, tail_d;
    fu_output_t     oq_q [2];

    logic [RRW:0]   w_sum;
    logic [RRW-1:0] w_idx;
    logic [RRW-1:0] w_gnt_idx;
    logic           w_any;
    logic           w_grant_en;
    logic           w_push;
    logic           w_pop;
    fu_input_t      w_alu_in;
    fu_output_t     w_alu_out;

    // Rotating priority search starting at rr_q, wrapping at NREQ.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, rr_q} + (RRW+1)'(k);
            if (w_sum >= (RRW+1)'(NREQ)) begin
                w_sum = w_sum - (RRW+1)'(NREQ);
            end
            w_idx = w_sum[RRW-1:0];
            if (!w_any && req_valid_i[w_idx]) begin
                w_any     = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
    end

    // Enable depends only on registered count, never on wb_ready_i.
    assign w_grant_en  = (count_q != C_FULL) && !flush_i;
    assign w_push      = w_grant_en && w_any;
    assign w_pop       = wb_valid_o && wb_ready_i;
    assign req_ready_o = w_push ? (NREQ'(1) << w_gnt_idx) : '0;

    assign w_alu_in = req_fuinput_i[w_gnt_idx];

    fu_alu u_alu (
        .in_i  (w_alu_in),
        .out_o (w_alu_out)
    );

    always_comb begin
        rr_d    = rr_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) begin
            count_d = '0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end else begin
            if (w_push) begin
                rr_d   = (w_gnt_idx == RRW'(NREQ-1)) ? '0 : w_gnt_idx + RRW'(1);
                tail_d = ~tail_q;
            end
            if (w_pop) begin
                head_d = ~head_q;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q    <= '0;
            count_q <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            oq_q[tail_q] <= w_alu_out;
        end
    end

    assign wb_valid_o    = (count_q != 2'd0);
    assign busy_o        = (count_q != 2'd0);
    assign wb_fuoutput_o = oq_q[head_q];
endmodule

`default_nettype wire

// File: tb/tb_fu_alu_sched.sv
// ============================================================================
// tb_fu_alu_sched : directed + randomized checks against a queue-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fu_alu_sched;
    import fu_alu_pkg::*;

    localparam int NREQ = 2;

    logic            clk      = 1'b0;
    logic            rst      = 1'b1;
    logic            flush    = 1'b0;
    logic            wb_ready = 1'b0;
    logic [NREQ-1:0] req_valid = '0;
    fu_input_t       req_in [NREQ];
    logic [NREQ-1:0] req_ready;
    logic            wb_valid;
    logic            busy;
    fu_output_t      wb_out;

    int n_checks = 0;
    int n_errs   = 0;

    fu_alu_sched #(.NREQ(NREQ), .OQ_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush),
        .req_valid_i   (req_valid),
        .req_fuinput_i (req_in),
        .req_ready_o   (req_ready),
        .wb_valid_o    (wb_valid),
        .wb_fuoutput_o (wb_out),
        .wb_ready_i    (wb_ready),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic fu_output_t model_alu(input fu_input_t u);
        longint r;
        case (u.op)
            ALU_ADD:  r = longint'(u.rs1 + u.rs2);
            ALU_SUB:  r = longint'(u.rs1 - u.rs2);
            ALU_SLT:  r = (longint'(u.rs1) < longint'(u.rs2)) ? 1 : 0;
            ALU_SLTU: r = (u.rs1 < u.rs2) ? 1 : 0;
            ALU_AND:  r = longint'(u.rs1 & u.rs2);
            ALU_OR:   r = longint'(u.rs1 | u.rs2);
            ALU_XOR:  r = longint'(u.rs1 ^ u.rs2);
            ALU_SLL:  r = longint'(u.rs1 << u.rs2[5:0]);
            ALU_SRL:  r = longint'(u.rs1 >> u.rs2[5:0]);
            ALU_SRA:  r = longint'(u.rs1) >>> u.rs2[5:0];
            ALU_ADDW: r = longint'(int'(u.rs1[31:0] + u.rs2[31:0]));
            ALU_SUBW: r = longint'(int'(u.rs1[31:0] - u.rs2[31:0]));
            default:  r = 0;
        endcase
        return '{pc: u.pc, id: u.id, prd: u.prd, rdval: 64'(r)};
    endfunction

    function automatic fu_input_t mk(input alu_op_e op, input logic [63:0] a, input logic [63:0] b,
                                     input logic [7:0] id, input logic [6:0] prd);
        return '{op: op, pc: {56'h1000, id}, id: id, prd: prd, rs1: a, rs2: b};
    endfunction

    // Behavioural model: FIFO of pending results plus the round-robin start port.
    fu_output_t      m_q [$];
    int              m_rr;
    int              m_g;
    logic [NREQ-1:0] m_rdy;

    always @(negedge clk) begin
        if (rst) begin
            m_q.delete();
            m_rr = 0;
        end else begin
            m_g   = -1;
            m_rdy = '0;
            if (m_q.size() < 2 && !flush) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_g < 0 && req_valid[(m_rr + k) % NREQ]) m_g = (m_rr + k) % NREQ;
                end
            end
            if (m_g >= 0) m_rdy[m_g] = 1'b1;
            check("m_req_ready", req_ready, m_rdy);
            check("m_wb_valid", wb_valid, m_q.size() != 0);
            check("m_busy", busy, m_q.size() != 0);
            if (m_q.size() != 0) check("m_wb_out", wb_out, m_q[0]);
            if (m_q.size() != 0 && wb_ready) void'(m_q.pop_front());
            if (flush) begin
                m_q.delete();
            end else if (m_g >= 0) begin
                m_q.push_back(model_alu(req_in[m_g]));
                m_rr = (m_g + 1) % NREQ;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        req_valid = '0;
        flush     = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    fu_input_t   bp_ops [3];
    int          grant_cyc [3];
    logic [63:0] popped [$];
    int          bp_idx;

    initial begin
        for (int p = 0; p < NREQ; p++) req_in[p] = '0;

        // Reset mid-stream with a full queue
        do_reset();
        wb_ready  = 1'b0;
        tick(); req_valid = '1;
        req_in[0] = mk(ALU_ADD, 64'd1, 64'd2, 8'h01, 7'd1);
        req_in[1] = mk(ALU_ADD, 64'd3, 64'd4, 8'h02, 7'd2);
        tick();
        tick(); req_valid = '0;
        #1 check("t1_full_busy", busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("t1_rst_valid", wb_valid, 1'b0);
        check("t1_rst_busy", busy, 1'b0);
        check("t1_rst_ready", req_ready, '0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) tick();
        #1;
        check("t1_idle_valid", wb_valid, 1'b0);
        check("t1_idle_busy", busy, 1'b0);
        check("t1_idle_ready", req_ready, '0);

        // Single op
        do_reset();
        wb_ready = 1'b1;
        tick(); req_valid = 2'b01; req_in[0] = mk(ALU_ADD, 64'd5, 64'd7, 8'h10, 7'd12);
        #2 check("t2_grant", req_ready, 2'b01);
        tick(); req_valid = '0;
        #2;
        check("t2_valid", wb_valid, 1'b1);
        check("t2_rdval", wb_out.rdval, 64'd12);
        check("t2_prd", wb_out.prd, 7'd12);
        tick();
        #2 check("t2_busy_low", busy, 1'b0);

        // Round-robin fairness
        do_reset();
        wb_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            req_valid = 2'b11;
            for (int p = 0; p < NREQ; p++)
                req_in[p] = mk(ALU_OR, 64'(i), 64'(p), 8'(16 * p + i), 7'(i));
            #2;
            check("t3_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) check("t3_order", wb_out.id, 8'(16 * ((i - 1) % 2) + (i - 1)));
        end
        tick(); req_valid = '0;

        // Back-pressure
        do_reset();
        bp_ops[0] = mk(ALU_SUB, 64'd10, 64'd3, 8'h20, 7'd20);
        bp_ops[1] = mk(ALU_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 8'h21, 7'd21);
        bp_ops[2] = mk(ALU_XOR, 64'hF0, 64'h3C, 8'h22, 7'd22);
        for (int j = 0; j < 3; j++) grant_cyc[j] = -1;
        popped.delete();
        bp_idx = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            tick();
            wb_ready = (cyc >= 5);
            if (bp_idx < 3) begin
                req_valid = 2'b10;
                req_in[1] = bp_ops[bp_idx];
            end else begin
                req_valid = '0;
            end
            #2;
            if (cyc >= 2 && cyc <= 4) check("t4_head_hold", wb_out.rdval, 64'd7);
            if (wb_valid && wb_ready) popped.push_back(wb_out.rdval);
            if (req_ready[1] && bp_idx < 3) begin
                grant_cyc[bp_idx] = cyc;
                bp_idx++;
            end
        end
        check("t4_grant0", grant_cyc[0], 0);
        check("t4_grant1", grant_cyc[1], 1);
        check("t4_grant2", grant_cyc[2], 6);
        check("t4_npop", popped.size(), 3);
        if (popped.size() == 3) begin
            check("t4_pop0", popped[0], 64'd7);
            check("t4_pop1", popped[1], 64'd1);
            check("t4_pop2", popped[2], 64'hCC);
        end

        // Flush preserves the round-robin pointer
        do_reset();
        wb_ready  = 1'b0;
        req_in[0] = mk(ALU_AND, 64'hFF, 64'h0F, 8'h30, 7'd30);
        req_in[1] = mk(ALU_SLL, 64'h1, 64'd4, 8'h31, 7'd31);
        tick(); req_valid = 2'b11;
        tick(); req_valid = 2'b01;
        tick(); req_valid = 2'b11; flush = 1'b1;
        #2 check("t5_no_grant", req_ready, '0);
        tick(); flush = 1'b0;
        #2;
        check("t5_valid_low", wb_valid, 1'b0);
        check("t5_rr_kept", req_ready, 2'b10);
        tick(); req_valid = '0; wb_ready = 1'b1;

        // Word op
        tick(); req_valid = 2'b01;
        req_in[0] = mk(ALU_ADDW, 64'h7FFF_FFFF, 64'd1, 8'h40, 7'd40);
        #2 check("t6_grant", req_ready[0], 1'b1);
        tick(); req_valid = '0;
        #2 check("t6_rdval", wb_out.rdval, 64'hFFFF_FFFF_8000_0000);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            tick();
            req_valid = NREQ'($urandom);
            for (int p = 0; p < NREQ; p++)
                req_in[p] = mk(alu_op_e'(4'($urandom_range(0, 11))),
                               ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom},
                               ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom},
                               8'($urandom), 7'($urandom));
            wb_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 31) == 0);
        end
        tick(); req_valid = '0; flush = 1'b0; wb_ready = 1'b1;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
